// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM states, framing constants
// and the 120-bit instruction word field layout. INSTR_LOADER_CHECKSUM_EN adds CHK.
package instr_loader_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam int         WORD_BYTES = 15;
    localparam int         WORD_W     = 8 * WORD_BYTES;

    localparam int FLG_MSB  = 119;
    localparam int FLG_LSB  = 56;
    localparam int OP_MSB   = 55;
    localparam int OP_LSB   = 52;
    localparam int DATA_MSB = 51;
    localparam int DATA_LSB = 32;
    localparam int TIME_MSB = 31;
    localparam int TIME_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_LO,
        S_ADDR_HI,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_WRITE
`ifdef INSTR_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

endpackage

// File: rtl/instr_loader.sv
// Host byte-stream loader writing 120-bit instruction words into instruction memory.
// Define INSTR_LOADER_CHECKSUM_EN to require a per-word XOR checksum byte.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_SIZE = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_waddr,
    output logic [WORD_W-1:0]    mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_t               state;
    logic [7:0]           lo_byte;
    logic [15:0]          cnt;
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_W-1:0]    word;
    logic [3:0]           idx;
    logic                 accept;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    assign byte_ready = (state != S_WRITE);
    assign busy       = (state != S_IDLE);
    assign accept     = byte_valid && byte_ready;
    assign mem_waddr  = addr;
    assign mem_wdata  = word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            lo_byte <= '0;
            cnt     <= '0;
            addr    <= '0;
            word    <= '0;
            idx     <= '0;
            mem_we  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            // A word already in WRITE is committed; any other busy state aborts on run.
            if (state != S_IDLE && state != S_WRITE && run) begin
                state <= S_IDLE;
                err   <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            if (byte_in == CMD_WRITE && !run) begin
                                err   <= 1'b0;
                                state <= S_ADDR_LO;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_ADDR_LO: begin
                        if (accept) begin
                            lo_byte <= byte_in;
                            state   <= S_ADDR_HI;
                        end
                    end
                    S_ADDR_HI: begin
                        if (accept) begin
                            addr  <= ADDR_SIZE'({byte_in, lo_byte});
                            state <= S_CNT_LO;
                        end
                    end
                    S_CNT_LO: begin
                        if (accept) begin
                            cnt[7:0] <= byte_in;
                            state    <= S_CNT_HI;
                        end
                    end
                    S_CNT_HI: begin
                        if (accept) begin
                            cnt[15:8] <= byte_in;
                            idx       <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                            csum      <= '0;
`endif
                            if ({byte_in, cnt[7:0]} == 16'd0) begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            word[{idx, 3'b000} +: 8] <= byte_in;
`ifdef INSTR_LOADER_CHECKSUM_EN
                            csum <= csum ^ byte_in;
`endif
                            if (idx == 4'(WORD_BYTES - 1)) begin
                                idx <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                                state <= S_CHK;
`else
                                state  <= S_WRITE;
                                mem_we <= 1'b1;
                                done   <= (cnt == 16'd1);
`endif
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
`ifdef INSTR_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (accept) begin
                            csum <= '0;
                            if (byte_in == csum) begin
                                state  <= S_WRITE;
                                mem_we <= 1'b1;
                                done   <= (cnt == 16'd1);
                            end else begin
                                err   <= 1'b1;
                                state <= S_DATA;
                            end
                        end
                    end
`endif
                    S_WRITE: begin
                        addr <= addr + ADDR_SIZE'(1);
                        cnt  <= cnt - 16'd1;
                        if (run) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else if (cnt == 16'd1) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: random frames, expected writes queued by a
// frame-level model, a negedge monitor pops and compares on every mem_we.
`timescale 1ns/1ps
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam int AS = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [AS-1:0]     mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic              err;

    instr_loader #(.ADDR_SIZE(AS)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AS-1:0]     addr;
        logic [WORD_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   done_alone = 0;
    int   exp_done_alone = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (mem_we) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h expected no write", mem_waddr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("waddr", 128'(mem_waddr), 128'(e.addr));
                    chk("wdata", 128'(mem_wdata), 128'(e.data));
                    chk("done_with_we", 128'(done), 128'(e.last));
                    chk("ready_in_write", 128'(byte_ready), 128'(0));
                end
            end else if (done) begin
                done_alone++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int unsigned guard;
        guard = 0;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: got 0 expected 1");
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    function automatic logic [WORD_W-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[WORD_W-1:0];
    endfunction

    task automatic send_word(input logic [WORD_W-1:0] w, input bit good_chk);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            send_byte(w[8*k +: 8]);
            x ^= w[8*k +: 8];
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(good_chk ? x : ~x);
`else
        if (!good_chk) x = '0;
`endif
    endtask

    task automatic send_header(input int base, input int cnt);
        send_byte(CMD_WRITE);
        send_byte(8'(base));
        send_byte(8'(base >> 8));
        send_byte(8'(cnt));
        send_byte(8'(cnt >> 8));
    endtask

    // Reference model: word i of a frame lands at (base + i) mod 2^AS.
    task automatic send_frame(input int base, input int cnt);
        exp_t e;
        send_header(base, cnt);
        if (cnt == 0) exp_done_alone++;
        for (int i = 0; i < cnt; i++) begin
            e.data = rand_word();
            e.addr = AS'((base + i) % (1 << AS));
            e.last = (i == cnt - 1);
            sb.push_back(e);
            send_word(e.data, 1'b1);
        end
        go_idle();
        @(negedge clk);
    endtask

    initial begin
        logic [WORD_W-1:0] w;
        int unsigned       guard;
        reset      = 1'b0;
        run        = 1'b0;
        byte_in    = '0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_we", 128'(mem_we), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 128'(byte_ready), 128'(1));
        chk("post_rst_done", 128'(done), 128'(0));

        send_frame(32'h0010, 2);
        chk("frame1_busy", 128'(busy), 128'(0));
        chk("frame1_err", 128'(err), 128'(0));

        send_frame(32'h7FFF, 2);
        send_frame(32'hFFF0, 1);
        send_frame(32'h0123, 0);
        chk("cnt0_busy", 128'(busy), 128'(0));

        send_byte(8'h55);
        go_idle();
        chk("badcmd_err", 128'(err), 128'(1));
        chk("badcmd_busy", 128'(busy), 128'(0));
        send_frame(int'($urandom_range(0, 65535)), int'($urandom_range(1, 3)));
        chk("recover_err", 128'(err), 128'(0));

        run = 1'b1;
        send_byte(CMD_WRITE);
        go_idle();
        chk("run_cmd_err", 128'(err), 128'(1));
        chk("run_cmd_busy", 128'(busy), 128'(0));
        run = 1'b0;

        // Abort with run on the 7th data byte.
        w = rand_word();
        send_header(32'h0200, 1);
        for (int k = 0; k < 6; k++) send_byte(w[8*k +: 8]);
        @(negedge clk);
        run     = 1'b1;
        byte_in = w[55:48];
        @(negedge clk);
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_err", 128'(err), 128'(1));
        run        = 1'b0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-word.
        send_header(32'h0300, 2);
        for (int k = 0; k < 5; k++) send_byte(8'(k + 1));
        @(negedge clk);
        byte_valid = 1'b0;
        reset      = 1'b0;
        #1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_we", 128'(mem_we), 128'(0));
        chk("midrst_ready", 128'(byte_ready), 128'(1));
        chk("midrst_waddr", 128'(mem_waddr), 128'(0));
        chk("midrst_wdata", 128'(mem_wdata), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        send_frame(32'h0300, 2);
        chk("after_rst_busy", 128'(busy), 128'(0));

`ifdef INSTR_LOADER_CHECKSUM_EN
        begin
            exp_t e;
            send_header(32'h0400, 1);
            e.data = rand_word();
            e.addr = AS'(32'h0400);
            e.last = 1'b1;
            send_word(e.data, 1'b0);
            go_idle();
            chk("chk_bad_err", 128'(err), 128'(1));
            chk("chk_bad_busy", 128'(busy), 128'(1));
            sb.push_back(e);
            send_word(e.data, 1'b1);
            go_idle();
            @(negedge clk);
            chk("chk_resend_busy", 128'(busy), 128'(0));
        end
`endif

        for (int i = 0; i < 4; i++)
            send_frame(int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        chk("sb_drained", 128'(sb.size()), 128'(0));
        chk("done_without_we", 128'(done_alone), 128'(exp_done_alone));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_SIZE, default 15, width of the instruction-memory address; SHALL be 1..16.
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-low.
REQ-004 run  input  1  sequencer running; while high, loads SHALL be refused.
REQ-005 byte_in  input  8  host byte stream.
REQ-006 byte_valid  input  1  byte_in valid.
REQ-007 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-008 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-009 mem_waddr  output  ADDR_SIZE  write address.
REQ-010 mem_wdata  output  120  instruction word: flg[119:56], op_code[55:52], data[51:32], time_arg[31:0].
REQ-011 busy  output  1  load in progress (state not IDLE).
REQ-012 done  output  1  one-cycle pulse when the last word of a load is written.
REQ-013 err  output  1  sticky error flag, cleared by the next accepted command byte.

Function
REQ-014 A byte SHALL be accepted only on a cycle with byte_valid and byte_ready both high.
REQ-015 Command frame: CMD(0x01), ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then CNT words of 15 bytes each, least-significant byte first.
REQ-016 FSM states: IDLE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA, WRITE, plus CHK when the checksum feature is compiled in (REQ-029).
REQ-017 IDLE: byte 0x01 with run low -> ADDR_LO; any other byte, or 0x01 with run high -> err set, remain IDLE, byte consumed.
REQ-018 Address bits above ADDR_SIZE-1 SHALL be ignored; address and count SHALL be little-endian 16-bit.
REQ-019 CNT_HI with an assembled count of 0 -> done pulse, return to IDLE, no write.
REQ-020 DATA: byte k (0..14) SHALL land in word bits [8k+7:8k]; the 15th byte -> WRITE.
REQ-021 WRITE lasts exactly one cycle: mem_we=1, byte_ready=0, and mem_waddr/mem_wdata hold the assembled values.
REQ-022 After WRITE, address increments modulo 2^ADDR_SIZE (wrap to 0) and count decrements; if the count reaches 0 -> done pulse in the same cycle as mem_we, then IDLE; else -> DATA.
REQ-023 byte_ready SHALL be 1 in every state except WRITE.
REQ-024 If run rises while busy, the FSM SHALL abandon the load: no further mem_we, err set, IDLE on the next cycle; a word whose WRITE cycle coincides with the rising run SHALL still be written.
REQ-025 mem_waddr/mem_wdata SHALL be registered outputs; their value is don't-care when mem_we=0.

Reset
REQ-026 Reset low SHALL asynchronously force IDLE and clear mem_we, done, err, busy, the count, the word and the address registers; byte_ready SHALL read 1 after release.
REQ-027 Reset mid-frame SHALL discard the partial word without any write; the next byte after release is treated as a command byte.

Configuration
REQ-028 Macro INSTR_LOADER_CHECKSUM_EN controls the checksum feature.
REQ-029 Defined: after each word's 15th byte -> CHK; the next byte SHALL equal the XOR of the 15 data bytes; match -> WRITE; mismatch -> word not written, err set, count and address unchanged, return to DATA so the host may resend the word.
REQ-030 Undefined: no CHK state; the frame is exactly as in REQ-015.

Structure
REQ-031 Package instr_loader_pkg SHALL hold the FSM state enum, CMD_WRITE=8'h01, WORD_BYTES=15, and the word field bit positions shared with the decoder.
REQ-032 No sub-module; a single FSM with datapath registers.

Verification
REQ-033 Load 01 10 00 02 00 + two words -> mem_we at addresses 0x0010 and 0x0011 with exact 120-bit data, done coincident with the second mem_we, busy low after.
REQ-034 ADDR=0x7FFF, CNT=2, ADDR_SIZE=15 -> writes at 0x7FFF and then 0x0000.
REQ-035 Command byte 0x55 -> err=1, no mem_we; a following valid 0x01 frame clears err and loads normally.
REQ-036 Assert run during the 7th data byte -> no mem_we, err=1, IDLE one cycle later; run asserted at the IDLE command byte -> refused with err.
REQ-037 Reset pulsed low mid-word -> all outputs at reset values immediately, no write; a fresh frame after release succeeds.
REQ-038 With INSTR_LOADER_CHECKSUM_EN: wrong checksum -> no write, err=1; correct resend -> write at the same address.
